seq_detector: RTL and testbench

SEQ_DETECTOR -- requirements
Module: seq_detector

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/input_debounce.sv | 51 +++++
 rtl/seq_detector.sv | 89 ++++++++
 tb/tb_seq_detector.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial 01[0*]1 sequence detector.
package seq_det_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S01  = 2'd2
    } state_e;

    // Any digit at 9 or above wraps to 0, so a digit can never leave 0..9.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
        return (d >= BCD_W'(9)) ? '0 : d + 1'b1;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser, stability-count debouncer and a one-clock pulse on
// each rising edge of the debounced level.
module input_debounce #(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic rise_o
);

    localparam int unsigned CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= sync_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    // The counter runs only while the input disagrees with the debounced
    // level; any agreement (a bounce) restarts it from zero.
    always_comb begin
        sync_d  = {sync_q[0], din_i};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rise_o = level_q & ~level_dly_q;

endmodule

// File: rtl/seq_detector.sv
// Detects 01[0*]1 on bits submitted by a debounced strobe and keeps a
// two-digit BCD count of matches.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk_50MHz,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_strobe,
    input  logic             clear,
    output logic             detect,
    output logic [BCD_W-1:0] hit_tens,
    output logic [BCD_W-1:0] hit_ones,
    output logic [1:0]       state_show
);

    logic [1:0]       bit_sync_q;
    logic             accept;
    logic             match;
    state_e           state_q, state_d;
    logic             detect_q, detect_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    input_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_strobe_db (
        .clk_i (clk_50MHz),
        .rst_ni(rst_n),
        .din_i (bit_strobe),
        .rise_o(accept)
    );

    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            bit_sync_q <= '0;
            state_q    <= IDLE;
            detect_q   <= 1'b0;
            tens_q     <= '0;
            ones_q     <= '0;
        end else begin
            bit_sync_q <= {bit_sync_q[0], bit_in};
            state_q    <= state_d;
            detect_q   <= detect_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        detect_d = 1'b0;
        tens_d   = tens_q;
        ones_d   = ones_q;
        match    = 1'b0;
        if (clear) begin
            state_d = IDLE;
            tens_d  = '0;
            ones_d  = '0;
        end else if (accept) begin
            case (state_q)
                IDLE:    state_d = bit_sync_q[1] ? IDLE : S0;
                S0:      state_d = bit_sync_q[1] ? S01  : S0;
                S01: begin
                    if (bit_sync_q[1]) begin
                        state_d = IDLE;
                        match   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (match) begin
                detect_d = 1'b1;
                ones_d   = bcd_inc(ones_q);
                if (ones_q >= BCD_W'(9)) begin
                    tens_d = bcd_inc(tens_q);
                end
            end
        end
    end

    assign detect     = detect_q;
    assign hit_tens   = tens_q;
    assign hit_ones   = ones_q;
    assign state_show = state_q;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: expected counts are queued per match and
// checked by a monitor whenever detect pulses.
module tb_seq_detector;

    logic       clk_50MHz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       bit_in    = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       clear     = 1'b0;
    logic       detect;
    logic [3:0] hit_tens;
    logic [3:0] hit_ones;
    logic [1:0] state_show;

    int checks = 0;
    int errors = 0;
    int ms     = 0;
    int mcount = 0;
    logic [7:0] exp_q[$];
    logic       prev_det = 1'b0;

    always #10 clk_50MHz = ~clk_50MHz;

    seq_detector #(
        .STABLE_CYCLES(2)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_strobe(bit_strobe),
        .clear     (clear),
        .detect    (detect),
        .hit_tens  (hit_tens),
        .hit_ones  (hit_ones),
        .state_show(state_show)
    );

    function automatic logic [7:0] to_bcd(input int c);
        logic [3:0] t, o;
        t = 4'(c / 10);
        o = 4'(c % 10);
        return {t, o};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every detect pulse must match the oldest queued count.
    always @(negedge clk_50MHz) begin
        if (rst_n && detect) begin
            checks++;
            if (prev_det) begin
                errors++;
                $display("FAIL detect_width: detect high on consecutive clocks at %0t", $time);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_detect: got count %h%h expected no detect at %0t",
                         hit_tens, hit_ones, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if ({hit_tens, hit_ones} !== e) begin
                    errors++;
                    $display("FAIL detect_count: got %h%h expected %h at %0t",
                             hit_tens, hit_ones, e, $time);
                end
            end
        end
        prev_det = rst_n && detect;
    end

    task automatic model_bit(input logic b);
        case (ms)
            0: ms = b ? 0 : 1;
            1: ms = b ? 2 : 1;
            default: begin
                if (b) begin
                    ms = 0;
                    mcount = (mcount + 1) % 100;
                    exp_q.push_back(to_bcd(mcount));
                end
            end
        endcase
    endtask

    // With clr_win set, clear is held across the clock where the FSM would act.
    task automatic submit(input logic b, input bit clr_win);
        @(negedge clk_50MHz) bit_in = b;
        repeat (3) @(negedge clk_50MHz);
        bit_strobe = 1'b1;
        if (clr_win) begin
            ms = 0;
            mcount = 0;
            repeat (3) @(negedge clk_50MHz);
            clear = 1'b1;
            repeat (3) @(negedge clk_50MHz);
            clear = 1'b0;
            repeat (2) @(negedge clk_50MHz);
        end else begin
            model_bit(b);
            repeat (8) @(negedge clk_50MHz);
        end
        bit_strobe = 1'b0;
        repeat (8) @(negedge clk_50MHz);
        chk("state_after_bit", {6'd0, state_show}, 8'(ms));
    endtask

    task automatic do_clear();
        @(negedge clk_50MHz) clear = 1'b1;
        @(negedge clk_50MHz) clear = 1'b0;
        ms = 0;
        mcount = 0;
        chk("clear_count", {hit_tens, hit_ones}, 8'h00);
        chk("clear_state", {6'd0, state_show}, 8'h00);
    endtask

    task automatic chk_end(input string name);
        chk(name, {hit_tens, hit_ones}, to_bcd(mcount));
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
    endtask

    logic [7:0] seq8;

    initial begin
        repeat (3) @(negedge clk_50MHz);
        chk("reset_detect", {7'd0, detect}, 8'h00);
        chk("reset_count", {hit_tens, hit_ones}, 8'h00);
        chk("reset_state", {6'd0, state_show}, 8'h00);
        rst_n = 1'b1;

        // 0,1,1 -> one match
        do_clear();
        submit(1'b0, 1'b0);
        submit(1'b1, 1'b0);
        submit(1'b1, 1'b0);
        chk_end("seq011_count");

        // 1,1,0,1,0,0,0,1 -> one match on the last bit
        do_clear();
        seq8 = 8'b1101_0001;
        for (int i = 7; i >= 0; i--) submit(seq8[i], 1'b0);
        chk_end("seq8_count");

        // Reset during a partial 0,1 while the completing 1 is being strobed
        submit(1'b0, 1'b0);
        submit(1'b1, 1'b0);
        @(negedge clk_50MHz);
        bit_in = 1'b1;
        bit_strobe = 1'b1;
        @(negedge clk_50MHz) rst_n = 1'b0;
        repeat (2) @(negedge clk_50MHz);
        rst_n = 1'b1;
        ms = 0;
        mcount = 0;
        chk("midreset_detect", {7'd0, detect}, 8'h00);
        chk("midreset_count", {hit_tens, hit_ones}, 8'h00);
        chk("midreset_state", {6'd0, state_show}, 8'h00);
        model_bit(1'b1);
        repeat (10) @(negedge clk_50MHz);
        bit_strobe = 1'b0;
        repeat (8) @(negedge clk_50MHz);
        chk("midreset_after", {6'd0, state_show}, 8'h00);
        chk_end("midreset_end");

        // Strobe glitch one clock shorter than STABLE_CYCLES is ignored
        do_clear();
        @(negedge clk_50MHz) bit_in = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        bit_strobe = 1'b1;
        @(negedge clk_50MHz) bit_strobe = 1'b0;
        repeat (10) @(negedge clk_50MHz);
        chk("glitch_state", {6'd0, state_show}, 8'h00);
        // Exactly STABLE_CYCLES clocks is accepted
        bit_strobe = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        bit_strobe = 1'b0;
        model_bit(1'b0);
        repeat (10) @(negedge clk_50MHz);
        chk("min_press_state", {6'd0, state_show}, 8'h01);

        // 100 matches: 99 then wrap to 00
        do_clear();
        for (int i = 1; i <= 100; i++) begin
            submit(1'b0, 1'b0);
            submit(1'b1, 1'b0);
            submit(1'b1, 1'b0);
            if (i == 99) chk("count_99", {hit_tens, hit_ones}, 8'h99);
            if (i == 100) chk("count_wrap", {hit_tens, hit_ones}, 8'h00);
        end
        chk_end("wrap_end");

        // clear beats the completing match at count 05
        do_clear();
        for (int i = 0; i < 5; i++) begin
            submit(1'b0, 1'b0);
            submit(1'b1, 1'b0);
            submit(1'b1, 1'b0);
        end
        chk("count_05", {hit_tens, hit_ones}, 8'h05);
        submit(1'b0, 1'b0);
        submit(1'b1, 1'b0);
        submit(1'b1, 1'b1);
        chk("clear_prio_detect", {7'd0, detect}, 8'h00);
        chk_end("clear_prio_count");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
